// File: rtl/mp_cache_tag_pkg.sv
// mp_cache_tag_pkg: shared state type, default widths and way priority encoder for the tag array
package mp_cache_tag_pkg;
  localparam int DEF_TAG_WIDTH  = 24;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_NUM_WAYS   = 4;
  localparam int MAX_WAYS       = 32;
  typedef enum logic {INIT, IDLE} state_t;
  function automatic logic [4:0] first_way(input logic [MAX_WAYS-1:0] v);
    first_way = '0;
    for (int i = MAX_WAYS - 1; i >= 0; i--)
      if (v[i]) first_way = 5'(i);
  endfunction
endpackage

// File: rtl/mp_cache_tag_way.sv
// mp_cache_tag_way: one way's tag+valid storage with registered read and tag compare
module mp_cache_tag_way #(
  parameter int TAG_WIDTH  = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  clr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [TAG_WIDTH-1:0]  din,
  input  logic                  vin,
  input  logic [TAG_WIDTH-1:0]  cmp_tag,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic                  vld,
  output logic                  hit
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  logic [TAG_WIDTH-1:0] tag_mem [RAM_DEPTH];
  logic [RAM_DEPTH-1:0] vld_mem;
  // the sweep also zeroes tags so dout never carries X from never-written sets
  always_ff @(posedge clk)
    if (we || clr) begin
      tag_mem[waddr] <= clr ? '0 : din;
      vld_mem[waddr] <= ~clr & vin;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag <= '0;
      vld <= 1'b0;
      hit <= 1'b0;
    end else if (rd) begin
      tag <= tag_mem[raddr];
      vld <= vld_mem[raddr];
      hit <= vld_mem[raddr] & (tag_mem[raddr] == cmp_tag);
    end
endmodule

// File: rtl/mp_cache_tag_array_nway.sv
// mp_cache_tag_array_nway: N-way tag store with parallel lookup, hit encoding and reset/flush sweep
module mp_cache_tag_array_nway
  import mp_cache_tag_pkg::*;
#(
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WAYS   = DEF_NUM_WAYS,
  parameter int WAY_IDX_W  = $clog2(NUM_WAYS)
) (
  input  logic                          clk0,
  input  logic                          rstb0,
  input  logic                          csb0,
  input  logic                          web0,
  input  logic [ADDR_WIDTH-1:0]         addr0,
  input  logic [NUM_WAYS-1:0]           wmask0,
  input  logic [TAG_WIDTH-1:0]          din0,
  input  logic                          vin0,
  input  logic [TAG_WIDTH-1:0]          cmp_tag0,
  input  logic                          flush0,
  output logic                          ready0,
  output logic [NUM_WAYS*TAG_WIDTH-1:0] dout0,
  output logic [NUM_WAYS-1:0]           vld0,
  output logic [NUM_WAYS-1:0]           hit0,
  output logic                          hit_any0,
  output logic [WAY_IDX_W-1:0]          hit_way0
);
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt, addr_q, waddr;
  logic [TAG_WIDTH-1:0]  cmp_q;
  logic                  rd_q, req, rd, wr, clr;
  always_ff @(posedge clk0 or negedge rstb0)
    if (!rstb0) begin
      state  <= INIT;
      cnt    <= '0;
      rd_q   <= 1'b0;
      addr_q <= '0;
      cmp_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == INIT) ? cnt + 1'b1 : '0;
      rd_q  <= rd;
      if (rd) begin
        addr_q <= addr0;
        cmp_q  <= cmp_tag0;
      end
    end
  // flush outranks a coincident request; flush during the sweep is ignored
  always_comb begin
    state_nx = (state == INIT) ? ((cnt == '1) ? IDLE : INIT) : (flush0 ? INIT : IDLE);
    ready0   = (state == IDLE);
    req      = ready0 & ~csb0 & ~flush0;
    rd       = req & web0;
    wr       = req & ~web0;
    clr      = (state == INIT);
    waddr    = clr ? cnt : addr0;
    hit_any0 = |hit0;
    hit_way0 = WAY_IDX_W'(first_way(MAX_WAYS'(hit0)));
  end
  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    mp_cache_tag_way #(.TAG_WIDTH(TAG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_way (
      .clk(clk0), .rst_n(rstb0), .we(wr & wmask0[w]), .clr(clr), .rd(rd_q),
      .waddr(waddr), .raddr(addr_q), .din(din0), .vin(vin0), .cmp_tag(cmp_q),
      .tag(dout0[w*TAG_WIDTH +: TAG_WIDTH]), .vld(vld0[w]), .hit(hit0[w])
    );
  end
endmodule

// File: tb/tb_mp_cache_tag_array_nway.sv
// tb_mp_cache_tag_array_nway: directed checks of sweep, lookup, hit encoding, flush and reset
module tb_mp_cache_tag_array_nway;
  logic        clk0 = 0, rstb0 = 0, csb0 = 1, web0 = 1, vin0 = 0, flush0 = 0;
  logic [3:0]  addr0 = 0, wmask0 = 0;
  logic [23:0] din0 = 0, cmp_tag0 = 0;
  logic        ready0, hit_any0;
  logic [95:0] dout0;
  logic [3:0]  vld0, hit0;
  logic [1:0]  hit_way0;
  int checks = 0, failures = 0;

  mp_cache_tag_array_nway dut (
    .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0), .addr0(addr0), .wmask0(wmask0),
    .din0(din0), .vin0(vin0), .cmp_tag0(cmp_tag0), .flush0(flush0), .ready0(ready0),
    .dout0(dout0), .vld0(vld0), .hit0(hit0), .hit_any0(hit_any0), .hit_way0(hit_way0)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [23:0] d, input logic v);
    addr0 = a; wmask0 = m; din0 = d; vin0 = v; csb0 = 0; web0 = 0;
    tick();
    csb0 = 1; web0 = 1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [23:0] c);
    addr0 = a; cmp_tag0 = c; csb0 = 0; web0 = 1;
    tick();
    csb0 = 1;
    tick();
  endtask

  task automatic sweep_chk(input string tag, input bit pulse_flush);
    for (int i = 0; i < 16; i++) begin
      chk(tag, ready0, 1'b0);
      if (pulse_flush && i == 5) flush0 = 1;
      tick();
      flush0 = 0;
    end
    chk({tag, "_up"}, ready0, 1'b1);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_ready", ready0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_hit", hit0, 0);
    chk("rst_hit_any", hit_any0, 0);
    chk("rst_hit_way", hit_way0, 0);
    rstb0 = 1;
    sweep_chk("init_sweep", 0);
    for (int s = 0; s < 16; s++) begin
      rd(4'(s), 24'h0);
      chk("empty_vld", vld0, 0);
      chk("empty_hit_any", hit_any0, 0);
    end

    wr(4'd3, 4'b0100, 24'hABCDEF, 1);
    rd(4'd3, 24'hABCDEF);
    chk("w2_vld", vld0, 4'b0100);
    chk("w2_hit", hit0, 4'b0100);
    chk("w2_hit_way", hit_way0, 2);
    chk("w2_dout", dout0[48 +: 24], 24'hABCDEF);
    wr(4'd3, 4'b0100, 24'h000001, 1);
    tick();
    chk("hold_hit", hit0, 4'b0100);
    chk("hold_dout", dout0[48 +: 24], 24'hABCDEF);
    rd(4'd3, 24'h000001);
    chk("rewrite_dout", dout0[48 +: 24], 24'h000001);
    wr(4'd3, 4'b0000, 24'h123456, 1);
    rd(4'd3, 24'h000001);
    chk("nomask_hit", hit0, 4'b0100);
    chk("nomask_dout", dout0[48 +: 24], 24'h000001);

    wr(4'd5, 4'b1010, 24'h111111, 1);
    rd(4'd5, 24'h111111);
    chk("two_hit", hit0, 4'b1010);
    chk("two_hit_way", hit_way0, 1);
    wr(4'd5, 4'b0010, 24'h111111, 0);
    rd(4'd5, 24'h111111);
    chk("inv_vld", vld0, 4'b1000);
    chk("inv_hit", hit0, 4'b1000);
    chk("inv_hit_way", hit_way0, 3);
    rd(4'd5, 24'h111112);
    chk("miss_hit", hit0, 0);
    chk("miss_hit_any", hit_any0, 0);
    chk("miss_hit_way", hit_way0, 0);

    wr(4'd7, 4'b1111, 24'h00F00D, 1);
    rd(4'd7, 24'h00F00D);
    chk("all_hit", hit0, 4'b1111);
    chk("all_hit_way", hit_way0, 0);
    chk("all_hit_any", hit_any0, 1);
    rd(4'd7, 24'h80F00D);
    chk("msb_miss", hit0, 0);

    for (int s = 0; s < 16; s++) wr(4'(s), 4'b1111, 24'(s + 1), 1);
    rd(4'd9, 24'd10);
    chk("fill_hit", hit0, 4'b1111);
    addr0 = 0; wmask0 = 4'b1111; din0 = 24'hDEAD; vin0 = 1; csb0 = 0; web0 = 0; flush0 = 1;
    tick();
    csb0 = 1; web0 = 1; flush0 = 0;
    sweep_chk("flush_sweep", 1);
    for (int s = 0; s < 16; s++) begin
      rd(4'(s), 24'(s + 1));
      chk("flush_vld", vld0, 0);
      chk("flush_hit_any", hit_any0, 0);
    end

    rstb0 = 0; #3; rstb0 = 1;
    repeat (7) tick();
    chk("mid_ready", ready0, 0);
    rstb0 = 0; #2;
    chk("mid_rst_ready", ready0, 0);
    chk("mid_rst_vld", vld0, 0);
    rstb0 = 1;
    sweep_chk("restart_sweep", 0);

    rd(4'd2, 24'h000000);
    chk("zero_hit_any", hit_any0, 0);
    chk("zero_hit_way", hit_way0, 0);
    chk("zero_vld", vld0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mp_cache_tag_array_nway.md
Name: mp_cache_tag_array_nway

Overview:
Parametrised N-way cache tag store that succeeds the single-way, fixed-size tag macro. It holds tag and valid bits per way and per set, reads all ways in parallel and compares them against a lookup tag. Valid bits are cleared by a built-in reset/flush sweep. It sits between the cache controller and the data arrays, and is shared by the I-cache and D-cache.

Parameters:
TAG_WIDTH, 24, tag bits per way
ADDR_WIDTH, 4, set-index bits; RAM_DEPTH = 1<<ADDR_WIDTH sets
NUM_WAYS, 4, associativity; power of two, >=2
WAY_IDX_W, $clog2(NUM_WAYS), width of the way index (derived; do not override)

Ports:
clk0 input 1 clock
rstb0 input 1 asynchronous active-low reset
csb0 input 1 active-low request select
web0 input 1 active-low write enable (1 = lookup/read)
addr0 input ADDR_WIDTH set index
wmask0 input NUM_WAYS per-way write enable
din0 input TAG_WIDTH tag written to the masked ways
vin0 input 1 valid bit written to the masked ways (0 = invalidate)
cmp_tag0 input TAG_WIDTH lookup tag compared on reads
flush0 input 1 single-cycle pulse; invalidates every set
ready0 output 1 array accepts requests
dout0 output NUM_WAYS*TAG_WIDTH read tags; way w at [w*TAG_WIDTH +: TAG_WIDTH]
vld0 output NUM_WAYS read valid bits
hit0 output NUM_WAYS per-way hit: vld & (tag == cmp_tag0 of the request)
hit_any0 output 1 OR of hit0
hit_way0 output WAY_IDX_W lowest-index hitting way; 0 when no way hits

Behaviour:
- Clocking and reset: one clock, clk0. rstb0 is asynchronous active-low. All state updates on posedge clk0; no negedge logic.
- Output reset values:
  - ready0=0
  - dout0, vld0, hit0, hit_any0 and hit_way0 = 0
  - FSM in INIT, sweep counter = 0
- Storage:
  - Tag+valid storage is a plain reg array with no reset; valid bits are cleared only by the sweep.
  - cmp_tag0 is registered alongside the address on read requests.
- FSM states:
  - INIT: each cycle clears valid for all ways of set cnt; cnt increments. When cnt == RAM_DEPTH-1, go to IDLE next cycle. Sweep takes exactly RAM_DEPTH cycles.
  - IDLE: ready0=1; serves requests.
- Flush:
  - flush0=1 in IDLE: go to INIT, cnt=0, ready0=0 next cycle. Flush wins over a coincident request, which is dropped.
  - flush0 during INIT is ignored; the sweep is not restarted.
- Reset mid-sweep or mid-operation: async return to INIT with cnt=0. The sweep restarts from set 0.
- Read (IDLE, csb0=0, web0=1, sampled at edge N):
  - dout0, vld0, hit0, hit_any0 and hit_way0 are valid after edge N+1 (1-cycle latency).
  - They hold their value until the next read completes.
- Write (IDLE, csb0=0, web0=0):
  - Each way with wmask0[w]=1 gets tag=din0 and valid=vin0 at this edge; unmasked ways are unchanged.
  - Outputs hold. wmask0=0 is a no-op.
- Read after write: a read of the same set on the next cycle returns the newly written data. The port is single, so there is no same-cycle read/write.
- Requests when ready0=0: ignored, with no state change.
- Hits:
  - Comparison is on the full TAG_WIDTH; an invalid way never hits.
  - With multiple hits, hit0 shows all of them; hit_way0 is the lowest index.
- No X on outputs after reset under any input sequence.

Decomposition:
- Package mp_cache_tag_pkg:
  - FSM state enum {INIT, IDLE}
  - way-index function (priority encoder)
  - default widths as localparams
- Sub-module mp_cache_tag_way: one way's tag+valid storage, read register and comparator, instantiated NUM_WAYS times by generate.
- Top-level holds: FSM, sweep counter, request registers, hit encoding.

Test Plan:
- Reset, then hold csb0=1: ready0=0 for 16 cycles, then 1 on cycle 17. A read of every set returns vld0=0000, hit_any0=0.
- Write set 3, wmask0=0100, din0=0xABCDEF, vin0=1; read set 3 with cmp_tag0=0xABCDEF: next cycle vld0=0100, hit0=0100, hit_way0=2, way-2 dout0 slice=0xABCDEF.
- Write 0x111111 to ways 1 and 3 of set 5; read with cmp_tag0=0x111111: hit0=1010, hit_way0=1. Then invalidate way 1 (vin0=0); read: hit0=1000, hit_way0=3.
- Fill sets 0..15, pulse flush0 together with a write request: the write is dropped, ready0 is low for 16 cycles, and all reads then give vld0=0.
- Deassert-to-reassert rstb0 at sweep cycle 7: ready0 stays 0, the sweep restarts, and ready0 rises 16 cycles after reset release.
- Read set 2 with cmp_tag0=0x000000 on an unwritten, swept set: hit_any0=0 and hit_way0=0, with no false hit.
